// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter in front of a 3-bit signed ALU.
//
// The winning requester's op/a/b are latched on grant. One cycle later the
// ALU result is registered. The result is then held (result_valid=1) until the
// owner acknowledges it, or until TIMEOUT DONE cycles have passed without an
// acknowledge; in that case the result is dropped and timeout_err pulses.
//
// Parameter:
//   TIMEOUT       DONE cycles waited for ack before the result is dropped (1..255)
//
// Optional build macro:
//   ALU_SEG_EN    when defined, seg carries a seven-segment pattern of the
//                 ADD/SUB result, registered on EXEC->DONE. When undefined,
//                 seg is tied to 00h and no decode logic exists.
//
// Ports:
//   clk_2         single clock, rising edge
//   reset_n       asynchronous active-low reset
//   req[1:0]      level request per requester, held until ack
//   op0/op1       operation per requester: 00 AND, 01 OR, 10 ADD, 11 SUB
//   a0/b0/a1/b1   signed 3-bit operands per requester
//   ack[1:0]      requester i has consumed the result (only the owner's bit counts)
//   gnt[1:0]      one-hot owner during EXEC and DONE
//   busy          high whenever the FSM is not idle
//   result[2:0]   registered ALU result, held until the next EXEC
//   result_valid  high in DONE only
//   ovf           signed overflow of the held result
//   timeout_err   one-cycle pulse when the DONE wait expires
//   seg[7:0]      seven-segment pattern of the held result
module alu_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk_2,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  input  logic [2:0] a0,
  input  logic [2:0] b0,
  input  logic [2:0] a1,
  input  logic [2:0] b1,
  input  logic [1:0] ack,
  output logic [1:0] gnt,
  output logic       busy,
  output logic [2:0] result,
  output logic       result_valid,
  output logic       ovf,
  output logic       timeout_err,
  output logic [7:0] seg
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  state_e     state_q;
  logic       owner_q;
  logic       last_owner_q;
  logic [1:0] op_q;
  logic [2:0] a_q;
  logic [2:0] b_q;
  logic [7:0] cnt_q;
  logic [1:0] gnt_q;
  logic       busy_q;
  logic [2:0] result_q;
  logic       valid_q;
  logic       ovf_q;
  logic       terr_q;

  logic       grant_owner_d;
  logic [3:0] alu_d;
  logic       owner_ack_d;
  logic [7:0] cnt_inc_d;

  // Returns {ovf, result}. Operands are sign-extended to 4 bits; the true
  // result fits -4..3 exactly when bits 3 and 2 of the 4-bit sum agree.
  function automatic logic [3:0] alu_calc(input logic [1:0] op,
                                          input logic [2:0] a,
                                          input logic [2:0] b);
    logic [3:0] sa;
    logic [3:0] sb;
    logic [3:0] t;
    sa = {a[2], a};
    sb = {b[2], b};
    t  = 4'b0000;
    case (op)
      2'b00: alu_calc = {1'b0, a & b};
      2'b01: alu_calc = {1'b0, a | b};
      2'b10: begin
        t = sa + sb;
        alu_calc = {t[3] ^ t[2], t[2:0]};
      end
      2'b11: begin
        t = sa - sb;
        alu_calc = {t[3] ^ t[2], t[2:0]};
      end
      default: alu_calc = 4'b0000;
    endcase
  endfunction

`ifdef ALU_SEG_EN
  logic [7:0] seg_q;

  // Seven-segment pattern for a signed 3-bit ADD/SUB result; logic ops show blank.
  function automatic logic [7:0] seg_decode(input logic [1:0] op,
                                            input logic [2:0] r);
    if (op[1] == 1'b0) begin
      seg_decode = 8'h00;
    end else begin
      case (r)
        3'b100:  seg_decode = 8'hE6;
        3'b101:  seg_decode = 8'hCF;
        3'b110:  seg_decode = 8'hDB;
        3'b111:  seg_decode = 8'h86;
        3'b000:  seg_decode = 8'h3F;
        3'b001:  seg_decode = 8'h06;
        3'b010:  seg_decode = 8'h5B;
        3'b011:  seg_decode = 8'h4F;
        default: seg_decode = 8'h00;
      endcase
    end
  endfunction
`endif

  // Arbitration choice, ALU evaluation and DONE-state helpers.
  always_comb begin
    grant_owner_d = 1'b0;
    if (req == 2'b11) begin
      // Tie: whoever was not served last wins.
      grant_owner_d = ~last_owner_q;
    end else if (req == 2'b10) begin
      grant_owner_d = 1'b1;
    end else begin
      grant_owner_d = 1'b0;
    end
    alu_d       = alu_calc(op_q, a_q, b_q);
    owner_ack_d = ack[owner_q];
    cnt_inc_d   = cnt_q + 8'd1;
  end

  // Main FSM: IDLE -> EXEC -> DONE -> IDLE with all outputs registered.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      op_q         <= 2'b00;
      a_q          <= 3'b000;
      b_q          <= 3'b000;
      cnt_q        <= 8'd0;
      gnt_q        <= 2'b00;
      busy_q       <= 1'b0;
      result_q     <= 3'b000;
      valid_q      <= 1'b0;
      ovf_q        <= 1'b0;
      terr_q       <= 1'b0;
`ifdef ALU_SEG_EN
      seg_q        <= 8'h00;
`endif
    end else begin
      terr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req != 2'b00) begin
            owner_q <= grant_owner_d;
            op_q    <= grant_owner_d ? op1 : op0;
            a_q     <= grant_owner_d ? a1 : a0;
            b_q     <= grant_owner_d ? b1 : b0;
            gnt_q   <= grant_owner_d ? 2'b10 : 2'b01;
            busy_q  <= 1'b1;
            state_q <= ST_EXEC;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          result_q <= alu_d[2:0];
          ovf_q    <= alu_d[3];
`ifdef ALU_SEG_EN
          seg_q    <= seg_decode(op_q, alu_d[2:0]);
`endif
          valid_q  <= 1'b1;
          cnt_q    <= 8'd0;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          // Owner ack wins over a simultaneous expiry.
          if (owner_ack_d || (cnt_inc_d == TIMEOUT_C)) begin
            terr_q       <= ~owner_ack_d;
            last_owner_q <= owner_q;
            gnt_q        <= 2'b00;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            cnt_q        <= 8'd0;
            state_q      <= ST_IDLE;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        default: begin
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt          = gnt_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign ovf          = ovf_q;
  assign timeout_err  = terr_q;
`ifdef ALU_SEG_EN
  assign seg          = seg_q;
`else
  assign seg          = 8'h00;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int TB_TIMEOUT = 4;

  logic       clk_2 = 1'b0;
  logic       reset_n;
  logic [1:0] req;
  logic [1:0] op0, op1;
  logic [2:0] a0, b0, a1, b1;
  logic [1:0] ack;
  logic [1:0] gnt;
  logic       busy;
  logic [2:0] result;
  logic       result_valid;
  logic       ovf;
  logic       timeout_err;
  logic [7:0] seg;

  alu_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk_2(clk_2), .reset_n(reset_n), .req(req),
    .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack(ack), .gnt(gnt), .busy(busy), .result(result),
    .result_valid(result_valid), .ovf(ovf), .timeout_err(timeout_err), .seg(seg)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct packed {
    logic [1:0] gnt;
    logic [2:0] res;
    logic       ovf;
    logic [7:0] seg;
  } exp_t;

  exp_t sb_q[$];
  int   vectors   = 0;
  int   miscomp   = 0;
  int   last_owner = 1;
  logic rv_prev   = 1'b0;
  logic [7:0] seg_tab [0:7] = '{8'hE6, 8'hCF, 8'hDB, 8'h86, 8'h3F, 8'h06, 8'h5B, 8'h4F};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscomp++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the arithmetic rules: compute the true signed value,
  // wrap it into 3 bits, flag values outside -4..3.
  function automatic exp_t ref_alu(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
    exp_t e;
    int sa = $signed(a);
    int sb = $signed(b);
    int t;
    int wrapped;
    e = '0;
    if (op == 2'd0) begin
      e.res = a & b;
    end else if (op == 2'd1) begin
      e.res = a | b;
    end else begin
      t = (op == 2'd2) ? sa + sb : sa - sb;
      e.ovf = (t < -4) || (t > 3);
      wrapped = ((t + 4) % 8 + 8) % 8 - 4;
      e.res = 3'(wrapped);
`ifdef ALU_SEG_EN
      e.seg = seg_tab[wrapped + 4];
`endif
    end
    return e;
  endfunction

  // Monitor: whenever a result is first presented, compare it to the oldest expectation.
  always @(negedge clk_2) begin
    exp_t e;
    if (result_valid && !rv_prev) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("mon_gnt", gnt, e.gnt);
        check("mon_result", result, e.res);
        check("mon_ovf", ovf, e.ovf);
        check("mon_seg", seg, e.seg);
      end
    end
    rv_prev = result_valid;
  end

  task automatic run_txn(input logic [1:0] r,
                         input logic [1:0] o0, input logic [2:0] x0, input logic [2:0] y0,
                         input logic [1:0] o1, input logic [2:0] x1, input logic [2:0] y1,
                         input int d, input bit give_ack, input bit nack, input bit do_reset);
    int   own;
    exp_t e;
    @(negedge clk_2);
    req = r; op0 = o0; a0 = x0; b0 = y0; op1 = o1; a1 = x1; b1 = y1; ack = 2'b00;
    if (r == 2'b11) own = 1 - last_owner;
    else            own = r[1] ? 1 : 0;
    e = ref_alu(own ? o1 : o0, own ? x1 : x0, own ? y1 : y0);
    e.gnt = (own == 1) ? 2'b10 : 2'b01;
    sb_q.push_back(e);
    @(negedge clk_2);
    check("gnt_exec", gnt, e.gnt);
    check("busy_exec", busy, 1'b1);
    check("rv_exec", result_valid, 1'b0);
    // Inputs wander while the operation is in flight.
    req = 2'($urandom); op0 = 2'($urandom); op1 = 2'($urandom);
    a0 = 3'($urandom); b0 = 3'($urandom); a1 = 3'($urandom); b1 = 3'($urandom);
    @(negedge clk_2);
    check("rv_done", result_valid, 1'b1);
    if (do_reset) begin
      #2 reset_n = 1'b0;
      #1;
      check("rst_gnt", gnt, 2'b00);
      check("rst_busy", busy, 1'b0);
      check("rst_result", result, 3'b000);
      check("rst_rv", result_valid, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      check("rst_terr", timeout_err, 1'b0);
      check("rst_seg", seg, 8'h00);
      @(negedge clk_2);
      req = 2'b00;
      reset_n = 1'b1;
      last_owner = 1;
      repeat (2) begin
        @(negedge clk_2);
        check("rst_no_terr", timeout_err, 1'b0);
      end
      return;
    end
    if (give_ack) begin
      for (int k = 0; k < d; k++) begin
        ack = nack ? ((own == 1) ? 2'b01 : 2'b10) : 2'b00;
        @(negedge clk_2);
        check("rv_hold", result_valid, 1'b1);
        check("gnt_hold", gnt, e.gnt);
      end
      ack = e.gnt;
      @(negedge clk_2);
      req = 2'b00; ack = 2'b00;
      check("ack_busy", busy, 1'b0);
      check("ack_gnt", gnt, 2'b00);
      check("ack_rv", result_valid, 1'b0);
      check("ack_terr", timeout_err, 1'b0);
      check("keep_result", result, e.res);
      check("keep_ovf", ovf, e.ovf);
      check("keep_seg", seg, e.seg);
    end else begin
      for (int k = 1; k < TB_TIMEOUT; k++) begin
        @(negedge clk_2);
        check("to_rv_hold", result_valid, 1'b1);
        check("to_no_terr", timeout_err, 1'b0);
      end
      @(negedge clk_2);
      req = 2'b00;
      check("to_terr", timeout_err, 1'b1);
      check("to_busy", busy, 1'b0);
      check("to_rv", result_valid, 1'b0);
      check("to_gnt", gnt, 2'b00);
      @(negedge clk_2);
      check("to_pulse_end", timeout_err, 1'b0);
    end
    last_owner = own;
  endtask

  initial begin
    reset_n = 1'b0; req = 2'b00; ack = 2'b00;
    op0 = 2'b00; op1 = 2'b00; a0 = 3'b000; b0 = 3'b000; a1 = 3'b000; b1 = 3'b000;
    #1;
    check("init_gnt", gnt, 2'b00);
    check("init_busy", busy, 1'b0);
    check("init_rv", result_valid, 1'b0);
    check("init_terr", timeout_err, 1'b0);
    check("init_seg", seg, 8'h00);
    repeat (2) @(negedge clk_2);
    reset_n = 1'b1;

    // ADD 3+1 -> -4 with overflow, acked immediately.
    run_txn(2'b01, 2'b10, 3'd3, 3'd1, 2'b00, 3'd0, 3'd0, 0, 1'b1, 1'b0, 1'b0);
    // Reset, then tie: requester 0 (AND) first, then requester 1 (SUB).
    reset_n = 1'b0; @(negedge clk_2); reset_n = 1'b1; last_owner = 1;
    run_txn(2'b11, 2'b00, 3'b111, 3'b011, 2'b11, 3'b100, 3'b001, 1, 1'b1, 1'b0, 1'b0);
    run_txn(2'b11, 2'b00, 3'b111, 3'b011, 2'b11, 3'b100, 3'b001, 0, 1'b1, 1'b0, 1'b0);
    // No ack: timeout.
    run_txn(2'b01, 2'b10, 3'd1, 3'd1, 2'b00, 3'd0, 3'd0, 0, 1'b0, 1'b0, 1'b0);
    // Non-owner ack ignored for two cycles, then owner ack.
    run_txn(2'b01, 2'b11, 3'd2, 3'd1, 2'b00, 3'd0, 3'd0, 2, 1'b1, 1'b1, 1'b0);
    // Ack arriving in the very cycle the timeout would fire.
    run_txn(2'b10, 2'b00, 3'd0, 3'd0, 2'b10, 3'd2, 3'd2, TB_TIMEOUT - 1, 1'b1, 1'b0, 1'b0);
    // OR 101|010 = 111, no overflow, blank segments.
    run_txn(2'b01, 2'b01, 3'b101, 3'b010, 2'b00, 3'd0, 3'd0, 0, 1'b1, 1'b0, 1'b0);
    // Reset mid-DONE, then a tie must go to requester 0.
    run_txn(2'b10, 2'b00, 3'd0, 3'd0, 2'b10, 3'd1, 3'd1, 0, 1'b1, 1'b0, 1'b1);
    run_txn(2'b11, 2'b10, 3'd1, 3'd2, 2'b11, 3'd3, 3'd1, 0, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      run_txn(2'($urandom_range(1, 3)),
              2'($urandom), 3'($urandom), 3'($urandom),
              2'($urandom), 3'($urandom), 3'($urandom),
              $urandom_range(0, TB_TIMEOUT - 1),
              ($urandom_range(0, 3) != 0), 1'($urandom), 1'b0);
    end

    repeat (2) @(negedge clk_2);
    check("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 15, the DONE-state cycles waited for ack before the result is dropped (legal 1..255).
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk_2  in  1  the single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  2  level request per requester (bit i = requester i), held until ack.
- op0, op1  in  2 each  operation: 00 AND, 01 OR, 10 ADD, 11 SUB.
- a0, b0, a1, b1  in  3 each  signed two's-complement operands.
- ack  in  2  requester i has consumed the result.
- gnt  out  2  one-hot owner, asserted during EXEC and DONE.
- busy  out  1  high when state is not IDLE.
- result  out  3  registered ALU result.
- result_valid  out  1  high in DONE only.
- ovf  out  1  signed overflow/underflow of the held result.
- timeout_err  out  1  one-cycle pulse on a TIMEOUT expiry.
- seg  out  8  seven-segment pattern of the held result.

Function
REQ-003 The block SHALL implement the FSM IDLE -> EXEC -> DONE -> IDLE, one state per cycle except DONE.
REQ-004 In IDLE with req != 0, it SHALL grant one requester, latch that requester's op/a/b, and enter EXEC.
- Single requester: granted.
- Both requesting: the requester not equal to last_owner is granted (round-robin).
REQ-005 In EXEC it SHALL compute from the latched operands, register result and ovf, and enter DONE.
REQ-006 Arithmetic SHALL be 3-bit:
- AND/OR: bitwise, ovf=0.
- ADD/SUB: wrap modulo 8; ovf=1 when the 4-bit sign-extended true result lies outside -4..3.
REQ-007 In DONE with ack[owner]=1, the block SHALL return to IDLE and set last_owner=owner.
REQ-008 ack from the non-owner SHALL be ignored in every state.
REQ-009 DONE timeout SHALL work as follows:
- An 8-bit counter clears on DONE entry and increments each DONE cycle without ack.
- When it reaches TIMEOUT: enter IDLE, pulse timeout_err for one cycle, set last_owner=owner.
REQ-010 Changes on req, op, a or b during EXEC/DONE SHALL NOT affect the in-flight operation.
REQ-011 ack[owner] in the same cycle the counter reaches TIMEOUT SHALL take priority: normal completion, no timeout_err.
REQ-012 gnt SHALL deassert in the cycle IDLE is re-entered; re-grant occurs at the earliest one cycle later (3-cycle minimum per operation).
REQ-013 result and ovf SHALL retain their last value after DONE until the next EXEC.

Reset
REQ-014 reset_n=0 SHALL immediately, asynchronously, set:
- state=IDLE
- gnt, busy, result, result_valid, ovf, timeout_err, seg all 0
- counter=0
- last_owner=1, so requester 0 wins the first tie.
REQ-015 Reset in EXEC or DONE SHALL discard the operation without asserting timeout_err.

Configuration
REQ-016 Macro ALU_SEG_EN defined: seg SHALL be registered on EXEC->DONE.
- ADD/SUB result patterns: -4 E6h, -3 CFh, -2 DBh, -1 86h, 0 3Fh, 1 06h, 2 5Bh, 3 4Fh.
- AND/OR: seg=00h.
- seg is retained until the next EXEC.
REQ-017 Macro ALU_SEG_EN undefined: seg SHALL be constant 00h and no decode logic SHALL be present.

Verification
REQ-018 The bench SHALL cover these scenarios:
- req=01, op0=10, a0=3, b0=1 -> gnt=01 next cycle; result_valid one cycle later; result=100b, ovf=1, seg=E6h; ack=01 -> IDLE next cycle.
- After reset, req=11, op0=00, a0=111b, b0=011b, op1=11, a1=100b, b1=001b -> requester 0 first: result=011b, ovf=0; then requester 1: result=011b, ovf=1, seg=4Fh.
- TIMEOUT=4, req=01, no ack -> result_valid high 4 cycles, then timeout_err pulses one cycle, busy=0.
- Owner 0 in DONE, ack=10 -> ignored, result_valid stays high; ack=01 -> completes.
- reset_n=0 mid-DONE -> all outputs 0 immediately, no timeout_err; the next tie grants requester 0.
- op0=01, a0=101b, b0=010b -> result=111b, ovf=0, seg=00h; with ALU_SEG_EN undefined, seg=00h in all scenarios.
